// File: rtl/scr1_pipe_vsum_seq_if.sv
// scr1_pipe_vsum_seq_if: command, operand, adder-array and result signals of the vector sum sequencer.
interface scr1_pipe_vsum_seq_if;
   logic         cmd_vld;
   logic         cmd_rdy;
   logic [1:0]   cmd_op;
   logic [5:0]   cmd_vl;
   logic         in_vld;
   logic         in_rdy;
   logic [255:0] in_op1;
   logic [255:0] in_op2;
   logic [255:0] sum_op1;
   logic [255:0] sum_op2;
   logic         sum_sub;
   logic [255:0] sum_res;
   logic [7:0]   sum_sign;
   logic         out_vld;
   logic         out_rdy;
   logic [255:0] out_data;
   logic [7:0]   out_mask;
   logic         out_last;
   logic         busy;

   modport slave (
      input  cmd_vld, cmd_op, cmd_vl, in_vld, in_op1, in_op2, sum_res, sum_sign, out_rdy,
      output cmd_rdy, in_rdy, sum_op1, sum_op2, sum_sub, out_vld, out_data, out_mask, out_last, busy
   );

   modport master (
      output cmd_vld, cmd_op, cmd_vl, in_vld, in_op1, in_op2, sum_res, sum_sign, out_rdy,
      input  cmd_rdy, in_rdy, sum_op1, sum_op2, sum_sub, out_vld, out_data, out_mask, out_last, busy
   );
endinterface

// File: rtl/scr1_pipe_vsum_seq.sv
// scr1_pipe_vsum_seq: streams 8-lane operand beats through the adder array and returns masked result beats.
module scr1_pipe_vsum_seq #(
   parameter int BEATS_MAX = 4
) (
   input logic                  clk,
   input logic                  rst,
   scr1_pipe_vsum_seq_if.slave  bus
);
   localparam int VL_MAX = 8 * BEATS_MAX;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t       r_state, w_next;
   logic [1:0]   r_op;
   logic [5:0]   r_vl;
   logic [2:0]   r_nbeats, r_cnt;
   logic         r_sub;
   logic         r_opnd_v, r_opnd_last;
   logic [7:0]   r_opnd_mask;
   logic [255:0] r_op1, r_op2;
   logic         r_out_vld, r_out_last;
   logic [7:0]   r_out_mask;
   logic [255:0] r_out_data;
   logic         w_cmd_fire, w_in_fire, w_in_rdy, w_adv, w_cmd_rdy, w_busy;
   logic [5:0]   w_vl;
   logic [2:0]   w_nbeats;
   logic [7:0]   w_mask;
   logic [255:0] w_res;

   assign w_vl       = (bus.cmd_vl > 6'(VL_MAX)) ? 6'(VL_MAX) : bus.cmd_vl;
   assign w_nbeats   = w_vl[5:3] + {2'b0, |w_vl[2:0]};
   assign w_adv      = r_opnd_v & (!r_out_vld | bus.out_rdy);
   assign w_cmd_fire = bus.cmd_vld & w_cmd_rdy;
   assign w_in_fire  = bus.in_vld & w_in_rdy;

   always_comb begin
      w_next    = r_state;
      w_cmd_rdy = 1'b0;
      w_in_rdy  = 1'b0;
      w_busy    = 1'b1;
      unique case (r_state)
         IDLE: begin
            w_cmd_rdy = 1'b1;
            w_busy    = 1'b0;
            w_next    = (bus.cmd_vld && w_vl != 6'd0) ? RUN : IDLE;
         end
         RUN: begin
            w_in_rdy = !r_opnd_v || w_adv;
            w_next   = (w_in_fire && r_cnt == r_nbeats - 3'd1) ? DRAIN : RUN;
         end
         // Leave once both stages will be empty after this edge.
         DRAIN:   w_next = (!r_opnd_v && (!r_out_vld || bus.out_rdy)) ? IDLE : DRAIN;
         default: w_next = IDLE;
      endcase
   end

   for (genvar i = 0; i < 8; i++) begin : g_lane
      assign w_mask[i] = {r_cnt, 3'(i)} < r_vl;
      assign w_res[32*i +: 32] = !r_opnd_mask[i] ? 32'd0 :
                                 !r_op[1] ? bus.sum_res[32*i +: 32] :
                                 !r_op[0] ? {31'd0, bus.sum_sign[i]} :
                                 bus.sum_sign[i] ? r_op1[32*i +: 32] : r_op2[32*i +: 32];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_op        <= '0;
         r_vl        <= '0;
         r_nbeats    <= '0;
         r_cnt       <= '0;
         r_sub       <= 1'b0;
         r_opnd_v    <= 1'b0;
         r_opnd_last <= 1'b0;
         r_opnd_mask <= '0;
         r_op1       <= '0;
         r_op2       <= '0;
         r_out_vld   <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_mask  <= '0;
         r_out_data  <= '0;
      end else begin
         r_state   <= w_next;
         r_opnd_v  <= w_in_fire | (r_opnd_v & !w_adv);
         r_out_vld <= w_adv | (r_out_vld & !bus.out_rdy);
         if (w_cmd_fire) begin
            r_op     <= bus.cmd_op;
            r_vl     <= w_vl;
            r_nbeats <= w_nbeats;
            r_cnt    <= '0;
            r_sub    <= |bus.cmd_op;
         end
         if (w_in_fire) begin
            r_cnt       <= r_cnt + 3'd1;
            r_op1       <= bus.in_op1;
            r_op2       <= bus.in_op2;
            r_opnd_mask <= w_mask;
            r_opnd_last <= r_cnt == r_nbeats - 3'd1;
         end
         if (w_adv) begin
            r_out_data <= w_res;
            r_out_mask <= r_opnd_mask;
            r_out_last <= r_opnd_last;
         end
      end
   end

   assign bus.cmd_rdy  = w_cmd_rdy;
   assign bus.in_rdy   = w_in_rdy;
   assign bus.busy     = w_busy;
   assign bus.sum_op1  = r_op1;
   assign bus.sum_op2  = r_op2;
   assign bus.sum_sub  = r_sub;
   assign bus.out_vld  = r_out_vld;
   assign bus.out_data = r_out_data;
   assign bus.out_mask = r_out_mask;
   assign bus.out_last = r_out_last;
endmodule
